// File: rtl/mem_arbiter.sv
// Arbitrates the single-port MEMORY between the CPU (default owner) and a debug/loader requester.
// Debug accesses stall the CPU at an instruction boundary, then do an AR load followed by read/write.
module mem_arbiter #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_R,
    input  logic       cpu_srcA,
    input  logic       cpu_wAR,
    input  logic       cpu_wM,
    input  logic       cpu_mmio,
    input  logic       cpu_idle,
    output logic       cpu_stall,
    input  logic       dbg_req,
    input  logic       dbg_we,
    input  logic [7:0] dbg_addr,
    input  logic [7:0] dbg_wdata,
    output logic       dbg_ack,
    output logic [7:0] dbg_rdata,
    input  logic [7:0] mem_M,
    output logic [7:0] mem_ADDR,
    output logic [7:0] mem_R,
    output logic       mem_srcA,
    output logic       mem_wAR,
    output logic       mem_wM,
    output logic       mem_mmio
);

    localparam logic [2:0] RdLat = 3'(RD_LAT);

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StLoad,
        StAccess,
        StDone,
        StCool
    } state_e;

    state_e     state;
    logic [2:0] cnt;
    logic       req_we;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;

    // Request fields are latched on acceptance so an early dbg_req drop still completes cleanly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            cnt       <= 3'd0;
            cpu_stall <= 1'b0;
            dbg_ack   <= 1'b0;
            dbg_rdata <= 8'h00;
            req_we    <= 1'b0;
            req_addr  <= 8'h00;
            req_wdata <= 8'h00;
        end else begin
            dbg_ack <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (dbg_req) begin
                        state     <= StWait;
                        cpu_stall <= 1'b1;
                        req_we    <= dbg_we;
                        req_addr  <= dbg_addr;
                        req_wdata <= dbg_wdata;
                    end
                end
                StWait: begin
                    if (cpu_idle) state <= StLoad;
                end
                StLoad: begin
                    state <= StAccess;
                    cnt   <= 3'd1;
                end
                StAccess: begin
                    if (req_we || cnt == RdLat) begin
                        if (!req_we) dbg_rdata <= mem_M;
                        state   <= StDone;
                        dbg_ack <= 1'b1;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                StDone: begin
                    state     <= StCool;
                    cpu_stall <= 1'b0;
                end
                StCool:  state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    // CPU strobes are dropped (not queued) while the debug side owns the bus.
    always_comb begin
        mem_ADDR = cpu_addr;
        mem_R    = cpu_R;
        mem_srcA = cpu_srcA;
        mem_wAR  = cpu_wAR;
        mem_wM   = cpu_wM;
        mem_mmio = cpu_mmio;
        unique case (state)
            StLoad: begin
                mem_ADDR = req_addr;
                mem_R    = req_wdata;
                mem_srcA = 1'b0;
                mem_wAR  = 1'b1;
                mem_wM   = 1'b0;
                mem_mmio = 1'b0;
            end
            StAccess: begin
                mem_ADDR = req_addr;
                mem_R    = req_wdata;
                mem_srcA = 1'b0;
                mem_wAR  = 1'b0;
                mem_wM   = req_we;
                mem_mmio = 1'b0;
            end
            StDone: begin
                mem_ADDR = req_addr;
                mem_R    = req_wdata;
                mem_srcA = 1'b0;
                mem_wAR  = 1'b0;
                mem_wM   = 1'b0;
                mem_mmio = 1'b0;
            end
            default: ;
        endcase
    end

endmodule
